// File: rtl/fre_pkg.sv
// Shared types and constants for the fre_meas_ctrl frequency measurement slice.
package fre_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        CAPTURE,
        CONVERT,
        UPDATE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int   MAX_DISP  = 9999;
    localparam bcd_t OVF_DIGIT = 4'd9;

    // One double-dabble correction: digits of 5 or more become >= 8 before the shift.
    function automatic bcd_t add3(input bcd_t d);
        return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start loads the binary value, BIN_W steps later
// done is high for one cycle while bcd carries the finished four-digit result.
module bin2bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [15:0]      bcd
);
    import fre_pkg::*;

    localparam int CNT_BITS = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    shreg;
    logic [15:0]         acc;
    logic [15:0]         adj;
    logic [CNT_BITS-1:0] step;
    logic                active;

    // bcd is the result of the step in progress, so on the last step it is the final value.
    always_comb begin
        adj  = {add3(acc[15:12]), add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
        bcd  = {adj[14:0], shreg[BIN_W-1]};
        done = active && (step == CNT_BITS'(BIN_W - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg  <= '0;
            acc    <= '0;
            step   <= '0;
            active <= 1'b0;
        end else if (start) begin
            shreg  <= bin;
            acc    <= '0;
            step   <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc   <= bcd;
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            step  <= step + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fre_meas_ctrl.sv
// Frequency meter controller: gate window, synchronised edge count, BCD publish.
// Define FRE_GATE_SEL_EN to add gate_sel (1/10 window, count scaled by 10).
module fre_meas_ctrl #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 14,
    parameter int MAX_DISP    = fre_pkg::MAX_DISP
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       wave_msb,
`ifdef FRE_GATE_SEL_EN
    input  logic       gate_sel,
`endif
    output logic [3:0] fre_thou,
    output logic [3:0] fre_hund,
    output logic [3:0] fre_ten,
    output logic [3:0] fre_one,
    output logic       meas_valid,
    output logic       busy,
    output logic       overflow
);
    import fre_pkg::*;

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam int                CAP_W     = CNT_W + 4;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
    localparam logic [CAP_W-1:0]  DISP_LIM  = CAP_W'(MAX_DISP);

    state_t            state, next_state;
    logic              sync1, sync2, prev, edge_hit;
    logic [GATE_W-1:0] gate_cnt, gate_lim;
    logic [CNT_W-1:0]  edge_cnt, conv_bin;
    logic [CAP_W-1:0]  cap_val;
    logic              cap_ovf, ovf, conv_start, conv_done, gate_entry;
    logic [15:0]       conv_bcd;

    // NOTE: non-blocking assignments make the three flops shift together on one edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= wave_msb;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_hit   = sync2 & ~prev;
    assign gate_entry = (state != GATE) && (next_state == GATE);

`ifdef FRE_GATE_SEL_EN
    localparam logic [GATE_W-1:0] GATE_LAST_SHORT = GATE_W'(GATE_CYCLES / 10 - 1);
    logic sel_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q <= 1'b0;
        end else if (gate_entry) begin
            sel_q <= gate_sel;
        end
    end

    assign gate_lim = sel_q ? GATE_LAST_SHORT : GATE_LAST;
    assign cap_val  = sel_q ? (CAP_W'(edge_cnt) << 3) + (CAP_W'(edge_cnt) << 1)
                            : CAP_W'(edge_cnt);
`else
    assign gate_lim = GATE_LAST;
    assign cap_val  = CAP_W'(edge_cnt);
`endif

    assign cap_ovf    = cap_val > DISP_LIM;
    assign conv_start = (state == CAPTURE);
    assign conv_bin   = cap_ovf ? '0 : cap_val[CNT_W-1:0];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default first, so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (en) next_state = GATE;
            GATE:    if (!en) next_state = IDLE;
                     else if (gate_cnt == gate_lim) next_state = CAPTURE;
            CAPTURE: next_state = CONVERT;
            CONVERT: if (conv_done) next_state = UPDATE;
            UPDATE:  next_state = en ? GATE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (gate_entry) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt + 1'b1;
                if (edge_hit && (edge_cnt != CNT_SAT)) begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end
            if (state == CAPTURE) begin
                ovf <= cap_ovf;
            end
        end
    end

    bin2bcd_seq #(
        .BIN_W (CNT_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (conv_start),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Digits and meas_valid register on the edge into UPDATE, so both are seen together there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {fre_thou, fre_hund, fre_ten, fre_one} <= '0;
            overflow   <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if ((state == CONVERT) && conv_done) begin
                meas_valid <= 1'b1;
                overflow   <= ovf;
                if (ovf) begin
                    {fre_thou, fre_hund, fre_ten, fre_one} <= {4{OVF_DIGIT}};
                end else begin
                    {fre_thou, fre_hund, fre_ten, fre_one} <= conv_bcd;
                end
            end
        end
    end

endmodule

// File: tb/tb_fre_meas_ctrl.sv
// Randomised bench for fre_meas_ctrl: edge counts and displayed digits come from a
// cycle-indexed log of the driven waveform and plain decimal arithmetic.
`timescale 1ns/1ps
module tb_fre_meas_ctrl;

    localparam int N_SMALL = 1000;
    localparam int N_BIG   = 20000;
    localparam int CW      = 14;
    localparam int LAT     = CW + 2;
    localparam int LOG_LEN = 100000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic en_s = 1'b0;
    logic en_b = 1'b0;
    logic wave = 1'b0;
`ifdef FRE_GATE_SEL_EN
    logic gate_sel = 1'b0;
`endif

    logic [3:0] s_thou, s_hund, s_ten, s_one, b_thou, b_hund, b_ten, b_one;
    logic       s_valid, s_busy, s_ovf, b_valid, b_busy, b_ovf;

    always #5 clk = ~clk;

    fre_meas_ctrl #(.GATE_CYCLES(N_SMALL), .CNT_W(CW), .MAX_DISP(9999)) dut_s (
        .clk(clk), .rstn(rstn), .en(en_s), .wave_msb(wave),
`ifdef FRE_GATE_SEL_EN
        .gate_sel(gate_sel),
`endif
        .fre_thou(s_thou), .fre_hund(s_hund), .fre_ten(s_ten), .fre_one(s_one),
        .meas_valid(s_valid), .busy(s_busy), .overflow(s_ovf)
    );

    fre_meas_ctrl #(.GATE_CYCLES(N_BIG), .CNT_W(CW), .MAX_DISP(9999)) dut_b (
        .clk(clk), .rstn(rstn), .en(en_b), .wave_msb(wave),
`ifdef FRE_GATE_SEL_EN
        .gate_sel(1'b0),
`endif
        .fre_thou(b_thou), .fre_hund(b_hund), .fre_ten(b_ten), .fre_one(b_one),
        .meas_valid(b_valid), .busy(b_busy), .overflow(b_ovf)
    );

    logic        use_big = 1'b0;
    logic [15:0] dig;
    logic        vld, bsy, ovf;
    assign dig = use_big ? {b_thou, b_hund, b_ten, b_one} : {s_thou, s_hund, s_ten, s_one};
    assign vld = use_big ? b_valid : s_valid;
    assign bsy = use_big ? b_busy : s_busy;
    assign ovf = use_big ? b_ovf : s_ovf;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Waveform log: wlog[c] is the wave level present at posedge number c.
    int wmode = 0;
    int wper  = 10;
    int cyc   = 0;
    bit wlog [0:LOG_LEN-1];

    always @(posedge clk) begin
        if (cyc < LOG_LEN) wlog[cyc] = wave;
        cyc = cyc + 1;
    end

    initial begin : wave_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            case (wmode)
                0:       wave = 1'b0;
                1:       wave = ((ph % wper) < (wper / 2)) ? 1'b1 : 1'b0;
                2:       wave = 1'($urandom_range(1, 0));
                default: wave = 1'b1;
            endcase
            ph++;
        end
    end

    // Gate cycle i follows posedge s+i; two synchroniser stages put the level sampled at
    // posedge s+i-1 against the one at s+i-2, so a rising edge there is counted in cycle i.
    function automatic int model_edges(input int s, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if ((s + i - 2 >= 0) && wlog[s + i - 1] && !wlog[s + i - 2]) c++;
        end
        return c;
    endfunction

    function automatic logic [16:0] model_disp(input int cnt);
        if (cnt > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(cnt / 1000), 4'((cnt / 100) % 10), 4'((cnt / 10) % 10), 4'(cnt % 10)};
    endfunction

    logic [16:0] held_s = '0;
    logic [16:0] held_b = '0;

    // Follow one window that began at posedge s; drop_after releases en in its UPDATE cycle.
    task automatic run_window(input int s, input int n, input int mult, input bit drop_after);
        int          budget;
        int          busy_low;
        int          drift;
        bit          got;
        logic [16:0] held;
        logic [16:0] exp;
        budget   = n + LAT + 20;
        busy_low = 0;
        drift    = 0;
        got      = 1'b0;
        held     = use_big ? held_b : held_s;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (vld) begin
                got = 1'b1;
            end else begin
                if (!bsy) busy_low++;
                if ({ovf, dig} !== held) drift++;
            end
        end
        if (drop_after) begin
            en_s = 1'b0;
            en_b = 1'b0;
        end
        exp = model_disp(model_edges(s, n) * mult);
        check("valid_seen", 32'(got), 32'd1);
        check("latency", cyc, s + n + LAT);
        check("digits", 32'(dig), 32'(exp[15:0]));
        check("overflow", 32'(ovf), 32'(exp[16]));
        check("busy_thru", busy_low, 0);
        check("hold_between", drift, 0);
        if (use_big) held_b = exp;
        else held_s = exp;
        @(negedge clk);
        check("valid_pulse", 32'(vld), 32'd0);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int s;
        int nv;
        repeat (3) @(negedge clk);
        check("rst_digits_s", 32'({s_thou, s_hund, s_ten, s_one}), 32'd0);
        check("rst_flags_s", 32'({s_valid, s_busy, s_ovf}), 32'd0);
        check("rst_digits_b", 32'({b_thou, b_hund, b_ten, b_one}), 32'd0);
        check("rst_flags_b", 32'({b_valid, b_busy, b_ovf}), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Period 10 then a random window, back to back.
        wmode = 1; wper = 10;
        en_s = 1'b1; s = cyc;
        run_window(s, N_SMALL, 1, 1'b0);
        check("p10_digits", 32'(dig), 32'h0100);
        wmode = 2;
        run_window(s + N_SMALL + LAT, N_SMALL, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_after_drop", 32'(bsy), 32'd0);

        // Reset during CONVERT.
        en_s = 1'b1; s = cyc;
        while (cyc < s + N_SMALL + 6) @(negedge clk);
        en_s = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_conv_digits", 32'(dig), 32'd0);
        check("rst_conv_flags", 32'({vld, bsy, ovf}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        held_s = '0; held_b = '0;
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (vld) nv++;
        end
        check("rst_conv_no_valid", nv, 0);

        // Constant level gives zero.
        wmode = 0;
        repeat (4) @(negedge clk);
        en_s = 1'b1; s = cyc;
        run_window(s, N_SMALL, 1, 1'b1);
        check("const_zero", 32'(dig), 32'h0000);

        // Random windows.
        for (int w = 0; w < 3; w++) begin
            wmode = int'($urandom_range(3, 0));
            wper  = int'($urandom_range(12, 2));
            repeat (int'($urandom_range(5, 1))) @(negedge clk);
            en_s = 1'b1; s = cyc;
            run_window(s, N_SMALL, 1, 1'b1);
        end

        // Abort mid-gate: no publish, outputs hold.
        wmode = 1; wper = 2;
        en_s = 1'b1; s = cyc;
        while (cyc < s + 400) @(negedge clk);
        en_s = 1'b0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (vld) nv++;
        end
        check("abort_no_valid", nv, 0);
        check("abort_hold", 32'({ovf, dig}), 32'(held_s));
        check("abort_idle", 32'(bsy), 32'd0);

        // Long window: 10000 edges saturate the display, then a 5000-edge window.
        use_big = 1'b1;
        en_b = 1'b1; s = cyc;
        run_window(s, N_BIG, 1, 1'b0);
        check("big_ovf_digits", 32'(dig), 32'h9999);
        check("big_ovf_flag", 32'(ovf), 32'd1);
        wper = 4;
        run_window(s + N_BIG + LAT, N_BIG, 1, 1'b1);
        check("big_clear_flag", 32'(ovf), 32'd0);
        use_big = 1'b0;

`ifdef FRE_GATE_SEL_EN
        // Short window with x10 scaling.
        wper = 10;
        gate_sel = 1'b1;
        repeat (2) @(negedge clk);
        en_s = 1'b1; s = cyc;
        run_window(s, N_SMALL / 10, 10, 1'b1);
        gate_sel = 1'b0;
        check("sel_digits", 32'(dig), 32'h0100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
